tt_pin_reg_responder: RTL
=========================

TT_PIN_REG_RESPONDER -- requirements
Module: tt_pin_reg_responder

Interface
REQ-001 Parameter NUM_REGS, default 16, number of 8-bit registers; power of two, 2..16.
REQ-002 Parameter SYNC_STAGES, default 2, synchronizer depth on host_stb; minimum 2.
REQ-003 clk  input  1  single clock; all state on rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 ena  input  1  design selected; when low, strobes are ignored and state holds.
REQ-006 host_data  input  8  command or data byte from host.
REQ-007 host_cmd  input  1  1 = host_data is a command byte, 0 = data byte.
REQ-008 host_stb  input  1  asynchronous host strobe; the rising edge marks a byte.
REQ-009 resp_data  output  8  read data to host.
REQ-010 resp_valid  output  1  resp_data holds valid read data.
REQ-011 err  output  1  sticky protocol-error flag.

Function
REQ-012 host_stb passes through a SYNC_STAGES flop chain; a byte event is the synchronized rising edge (last stage high, one stage later low).
REQ-013 host_data and host_cmd are sampled on the byte-event cycle; the host holds them stable from strobe rise to strobe fall.
REQ-014 Command byte fields: bit7 = 1 read / 0 write; bits[3:0] address; bits[6:4] ignored.
REQ-015 Addresses at or above NUM_REGS read as 0x00, ignore writes, and set err.
REQ-016 FSM states: IDLE, WAIT_DATA, RESP.
REQ-017 IDLE + write command -> WAIT_DATA, latching the address.
REQ-018 WAIT_DATA + data byte -> the register is written and the state returns to IDLE.
REQ-019 IDLE or RESP + read command -> RESP; resp_data loaded and resp_valid set one cycle after the event.
REQ-020 RESP holds resp_data/resp_valid until the next byte event, which clears resp_valid in the same cycle.
REQ-021 A data byte in IDLE or RESP -> ignored, err set (unless REQ-030).
REQ-022 A command byte in WAIT_DATA -> the pending write is abandoned, err set, and the new command is processed normally.
REQ-023 Register 0 reads a constant 0xA5 ID; writes to it are ignored without error.
REQ-024 A read of an address in the same cycle as a write to it returns the new value.
REQ-025 ena low: byte events are dropped; the synchronizer keeps running so that no spurious edge occurs when ena rises.
REQ-026 A write command with address 0xF and data bit0 = 1 clears err; this is the only clear path besides reset.

Reset
REQ-027 rst clears the FSM to IDLE, the synchronizer flops, all registers, the latched address, resp_data, resp_valid and err to 0.
REQ-028 rst asserted mid-transaction abandons it; the first byte after reset is decoded from IDLE.

Configuration
REQ-029 Macro REGRESP_AUTOINC_EN selects burst writes.
REQ-030 Defined: after a write completes, the FSM stays in a BURST sub-mode of WAIT_DATA; each further data byte writes address+1, wrapping modulo NUM_REGS; a command byte ends the burst without setting err.
REQ-031 Undefined: behaviour is exactly REQ-018 and REQ-021; no burst logic is present.

Structure
REQ-032 Shared package tt_regresp_pkg: FSM state enum, command bit positions, ID constant 0xA5, clear address 0xF.
REQ-033 Sub-module tt_sync_edge holds the synchronizer and rising-edge detector and is reused for other TT inputs.

Verification
REQ-034 Reset: rst pulse -> resp_data = 0x00, resp_valid = 0, err = 0; read of address 0 -> 0xA5.
REQ-035 Write/read: cmd 0x03, data 0x5C, cmd 0x83 -> resp_data = 0x5C with resp_valid high; edge-to-update latency is SYNC_STAGES+1 cycles.
REQ-036 Error: data byte in IDLE -> err = 1; write cmd 0x0F with data 0x01 -> err = 0.
REQ-037 Abandon: cmd 0x04, then cmd 0x84 -> err = 1, resp_data = 0x00, register 4 unchanged.
REQ-038 Burst (macro defined): cmd 0x0E, data 0x11, 0x22, 0x33 -> reg14 = 0x11, reg15 = 0x22; address wraps to 0, so 0x33 is dropped at the ID register.
REQ-039 ena gating and reset mid-operation: strobes with ena = 0 -> no state change; rst asserted in WAIT_DATA -> IDLE, with no write on the next data byte and err set.

Source files
------------

// File: rtl/tt_regresp_pkg.sv
// -----------------------------------------------------------------------------
// tt_regresp_pkg
// Shared definitions for the pin-driven register responder: FSM state
// encoding, command byte field positions, the read-only ID value and the
// error-clear address, plus a small address range helper.
// -----------------------------------------------------------------------------
package tt_regresp_pkg;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_WAIT_DATA = 2'd1,
    ST_RESP      = 2'd2
  } state_e;

  // Command byte layout: bit7 selects read (1) / write (0), bits[3:0] address.
  localparam int         CMD_RW_BIT = 7;
  localparam int         ADDR_W     = 4;

  localparam logic [3:0] ID_ADDR    = 4'h0;
  localparam logic [7:0] ID_VALUE   = 8'hA5;
  localparam logic [3:0] CLR_ADDR   = 4'hF;

  // True when the 4-bit address maps onto an implemented register.
  function automatic logic addr_in_range(input logic [ADDR_W-1:0] addr,
                                         input int num_regs);
    return (int'(addr) < num_regs);
  endfunction

endpackage

// File: rtl/tt_sync_edge.sv
// -----------------------------------------------------------------------------
// tt_sync_edge
// Multi-flop synchronizer for an asynchronous input followed by a rising
// edge detector.  A rise is reported for one cycle when the last synchronizer
// stage is high and the stage behind it (one cycle older) is still low.
//
// Ports:
//   clk      in   clock
//   rst      in   asynchronous active-high reset
//   async_in in   asynchronous level to synchronize
//   rise     out  one-cycle pulse on the synchronized rising edge
// -----------------------------------------------------------------------------
module tt_sync_edge #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic async_in,
  output logic rise
);

  logic [STAGES-1:0] chain_r;
  logic              last_r;

  // Synchronizer chain plus one extra flop holding the previous synced level.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      chain_r <= {STAGES{1'b0}};
      last_r  <= 1'b0;
    end else begin
      chain_r <= {chain_r[STAGES-2:0], async_in};
      last_r  <= chain_r[STAGES-1];
    end
  end

  assign rise = chain_r[STAGES-1] & ~last_r;

endmodule

// File: rtl/tt_pin_reg_responder.sv
// -----------------------------------------------------------------------------
// tt_pin_reg_responder
// Byte-wide register file driven by a slow asynchronous host strobe.  The
// host sends command bytes (bit7 read/write, bits[3:0] address) and data
// bytes; reads return the register on resp_data with resp_valid held until
// the next byte.  Register 0 is a read-only ID (0xA5).  Protocol errors set a
// sticky err flag, cleared by writing data with bit0 = 1 to address 0xF.
//
// Optional feature macro: REGRESP_AUTOINC_EN -- burst writes; after a write
// the FSM stays in WAIT_DATA and each further data byte writes the next
// address (modulo NUM_REGS) until a command byte arrives.
//
// Ports:
//   clk        in   clock, all state on rising edge
//   rst        in   asynchronous active-high reset
//   ena        in   design selected; byte events dropped while low
//   host_data  in   [7:0] command or data byte
//   host_cmd   in   1 = command byte, 0 = data byte
//   host_stb   in   asynchronous strobe, rising edge marks a byte
//   resp_data  out  [7:0] read data
//   resp_valid out  resp_data holds valid read data
//   err        out  sticky protocol-error flag
// -----------------------------------------------------------------------------
module tt_pin_reg_responder
  import tt_regresp_pkg::*;
#(
  parameter int NUM_REGS    = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ena,
  input  logic [7:0] host_data,
  input  logic       host_cmd,
  input  logic       host_stb,
  output logic [7:0] resp_data,
  output logic       resp_valid,
  output logic       err
);

  localparam int IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

  state_e     state_r, state_nx_s;
  logic [3:0] addr_r, addr_nx_s;
  logic [7:0] regs_r [NUM_REGS];
  logic [7:0] resp_data_r, resp_data_nx_s;
  logic       resp_valid_r, resp_valid_nx_s;
  logic       err_r, err_nx_s;
  logic       wr_en_s;
  logic       stb_rise_s;
  logic       evt_s;
  logic [3:0] rd_addr_s;
  logic [7:0] rd_val_s;
  logic       abandon_s;
  logic       clear_ok_s;

`ifdef REGRESP_AUTOINC_EN
  localparam logic [3:0] ADDR_MASK = 4'(NUM_REGS - 1);
  logic burst_r, burst_nx_s;
  // A command ends a burst silently; only a first-byte abandon is an error,
  // and only the command-addressed write to 0xF may clear err.
  assign abandon_s  = (state_r == ST_WAIT_DATA) && !burst_r;
  assign clear_ok_s = (addr_r == CLR_ADDR) && !burst_r;
`else
  assign abandon_s  = (state_r == ST_WAIT_DATA);
  assign clear_ok_s = (addr_r == CLR_ADDR);
`endif

  tt_sync_edge #(
    .STAGES (SYNC_STAGES)
  ) u_stb_sync (
    .clk      (clk),
    .rst      (rst),
    .async_in (host_stb),
    .rise     (stb_rise_s)
  );

  // The synchronizer always runs; only the resulting event is gated by ena.
  assign evt_s     = stb_rise_s & ena;
  assign rd_addr_s = host_data[3:0];

  // Read mux: ID at address 0, zero for unimplemented addresses.  Reads and
  // writes come from distinct byte events, at least two cycles apart, so the
  // register array already holds any earlier write when a read is decoded.
  always_comb begin
    rd_val_s = 8'h00;
    if (rd_addr_s == ID_ADDR) begin
      rd_val_s = ID_VALUE;
    end else if (addr_in_range(rd_addr_s, NUM_REGS)) begin
      rd_val_s = regs_r[rd_addr_s[IDX_W-1:0]];
    end else begin
      rd_val_s = 8'h00;
    end
  end

  // Next-state and output decode for one byte event.
  always_comb begin
    state_nx_s      = state_r;
    addr_nx_s       = addr_r;
    resp_data_nx_s  = resp_data_r;
    resp_valid_nx_s = resp_valid_r;
    err_nx_s        = err_r;
    wr_en_s         = 1'b0;
`ifdef REGRESP_AUTOINC_EN
    burst_nx_s      = burst_r;
`endif
    if (evt_s) begin
      resp_valid_nx_s = 1'b0;
      if (host_cmd) begin
`ifdef REGRESP_AUTOINC_EN
        burst_nx_s = 1'b0;
`endif
        if (abandon_s || !addr_in_range(rd_addr_s, NUM_REGS)) begin
          err_nx_s = 1'b1;
        end else begin
          err_nx_s = err_r;
        end
        if (host_data[CMD_RW_BIT]) begin
          resp_data_nx_s  = rd_val_s;
          resp_valid_nx_s = 1'b1;
          state_nx_s      = ST_RESP;
        end else begin
          addr_nx_s  = rd_addr_s;
          state_nx_s = ST_WAIT_DATA;
        end
      end else begin
        case (state_r)
          ST_WAIT_DATA: begin
            wr_en_s = addr_in_range(addr_r, NUM_REGS) && (addr_r != ID_ADDR);
            if (clear_ok_s && host_data[0]) begin
              err_nx_s = 1'b0;
            end else begin
              err_nx_s = err_r;
            end
`ifdef REGRESP_AUTOINC_EN
            burst_nx_s = 1'b1;
            addr_nx_s  = (addr_r + 4'd1) & ADDR_MASK;
            state_nx_s = ST_WAIT_DATA;
`else
            state_nx_s = ST_IDLE;
`endif
          end
          ST_IDLE, ST_RESP: begin
            err_nx_s   = 1'b1;
            state_nx_s = ST_IDLE;
          end
          default: begin
            state_nx_s = ST_IDLE;
          end
        endcase
      end
    end else begin
      state_nx_s = state_r;
    end
  end

  // FSM, latched address and response/error registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r      <= ST_IDLE;
      addr_r       <= 4'h0;
      resp_data_r  <= 8'h00;
      resp_valid_r <= 1'b0;
      err_r        <= 1'b0;
`ifdef REGRESP_AUTOINC_EN
      burst_r      <= 1'b0;
`endif
    end else begin
      state_r      <= state_nx_s;
      addr_r       <= addr_nx_s;
      resp_data_r  <= resp_data_nx_s;
      resp_valid_r <= resp_valid_nx_s;
      err_r        <= err_nx_s;
`ifdef REGRESP_AUTOINC_EN
      burst_r      <= burst_nx_s;
`endif
    end
  end

  // Register file storage; entry 0 is never written (ID is a constant).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_r[i] <= 8'h00;
      end
    end else if (wr_en_s) begin
      regs_r[addr_r[IDX_W-1:0]] <= host_data;
    end
  end

  assign resp_data  = resp_data_r;
  assign resp_valid = resp_valid_r;
  assign err        = err_r;

endmodule
